// File: rtl/mem_port_ctrl_if.sv
// rtl/mem_port_ctrl_if.sv - request/grant/response bus between mem_port_ctrl and unified memory
interface mem_port_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - memory port sequencer feeding IR/MDR and stalling the control unit via busy
// Optional alignment check on word accesses enabled by defining MEM_ALIGN_CHECK_EN.
module mem_port_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              lorD,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    mem_port_ctrl_if.master   bus,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              err,
    output logic              misalign
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              to_ir_q, to_ir_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [15:0]       tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              mis_q, mis_d;

    logic              req_any;
    logic [ADDR_W-1:0] sel_addr;
    logic              addr_bad;

    assign req_any  = mem_read | mem_write;
    assign sel_addr = lorD ? alu_out : pc;

`ifdef MEM_ALIGN_CHECK_EN
    assign addr_bad = |sel_addr[1:0];
`else
    assign addr_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        to_ir_d = to_ir_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        mis_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    addr_d  = sel_addr;
                    we_d    = mem_write;
                    wdata_d = wdata;
                    to_ir_d = ir_write & ~lorD;
                    tmo_d   = 16'd0;
                    // A misaligned access never reaches the bus; DONE still releases the stall.
                    if (addr_bad) begin
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                tmo_d = tmo_q + 16'd1;
                if (bus.bus_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + 16'd1;
                if (bus.bus_rvalid) begin
                    if (to_ir_q) ir_d  = bus.bus_rdata;
                    else         mdr_d = bus.bus_rdata;
                    state_d = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            to_ir_q <= 1'b0;
            ir_q    <= '0;
            mdr_q   <= '0;
            tmo_q   <= 16'd0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            to_ir_q <= to_ir_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.bus_req   = (state_q == S_REQ);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

    assign busy     = ((state_q == S_IDLE) & req_any) | (state_q == S_REQ) | (state_q == S_WAIT);
    assign ir       = ir_q;
    assign mdr      = mdr_q;
    assign err      = err_q;
    assign misalign = mis_q;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - scoreboard bench for mem_port_ctrl with a cycle-level memory responder
module tb_mem_port_ctrl;
    localparam int TMO = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, lorD, ir_write;
    logic [31:0] pc, alu_out, wdata;
    logic [31:0] ir, mdr;
    logic        busy, err, misalign;

    int   n_cmp = 0;
    int   n_mis = 0;
    req_t exp_q[$];
    logic [31:0] model_ir = '0;
    logic [31:0] model_mdr = '0;
    logic        model_err = 1'b0;

    mem_port_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_port_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .lorD     (lorD),
        .ir_write (ir_write),
        .pc       (pc),
        .alu_out  (alu_out),
        .wdata    (wdata),
        .bus      (bus_if),
        .ir       (ir),
        .mdr      (mdr),
        .busy     (busy),
        .err      (err),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One control-unit access: hold the request until busy drops, acting as the memory slave.
    task automatic access(input logic rd, input logic wr, input logic ld, input logic irw,
                          input logic [31:0] pc_i, input logic [31:0] alu_i, input logic [31:0] wd,
                          input logic [31:0] rdat, input int gnt_dly, input int rv_dly,
                          input int exp_busy, input string tag);
        logic [31:0] a;
        logic        bad;
        req_t        e;
        int          busy_n, req_n, first_req, wcnt;
        bit          granted, done;
        a = ld ? alu_i : pc_i;
        bad = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        bad = (a[1:0] != 2'b00);
`endif
        busy_n = 0; req_n = 0; first_req = -1; wcnt = 0; granted = 0; done = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; lorD = ld; ir_write = irw;
        pc = pc_i; alu_out = alu_i; wdata = wd;
        if (!bad && gnt_dly >= 0) exp_q.push_back('{we: wr, addr: a, wdata: wd});
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            bus_if.bus_gnt = 1'b0;
            bus_if.bus_rvalid = 1'b0;
            if (!busy) begin
                done = 1;
                break;
            end
            busy_n++;
            if (bus_if.bus_req) begin
                if (first_req < 0) first_req = cyc;
                if (req_n == gnt_dly) begin
                    bus_if.bus_gnt = 1'b1;
                    granted = 1;
                    if (exp_q.size() == 0) begin
                        check_val({tag, " unexpected req"}, 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val({tag, " bus_we"}, 64'(bus_if.bus_we), 64'(e.we));
                        check_val({tag, " bus_addr"}, 64'(bus_if.bus_addr), 64'(e.addr));
                        if (e.we) check_val({tag, " bus_wdata"}, 64'(bus_if.bus_wdata), 64'(e.wdata));
                    end
                end
                req_n++;
            end else if (granted && !wr) begin
                if (wcnt == rv_dly) begin
                    bus_if.bus_rvalid = 1'b1;
                    bus_if.bus_rdata  = rdat;
                end
                wcnt++;
            end
        end
        check_val({tag, " reached DONE"}, 64'(done), 64'd1);
        mem_read = 1'b0; mem_write = 1'b0;
        if (gnt_dly < 0 && !bad) begin
            model_err = 1'b1;
            check_val({tag, " req cycles"}, 64'(req_n), 64'(TMO));
        end else if (rd && !wr && !bad) begin
            if (irw && !ld) model_ir = rdat;
            else            model_mdr = rdat;
        end
        check_val({tag, " busy cycles"}, 64'(busy_n), 64'(exp_busy));
        check_val({tag, " first req cycle"}, 64'(first_req), bad ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd1);
        check_val({tag, " ir"}, 64'(ir), 64'(model_ir));
        check_val({tag, " mdr"}, 64'(mdr), 64'(model_mdr));
        check_val({tag, " err"}, 64'(err), 64'(model_err));
        check_val({tag, " misalign"}, 64'(misalign), 64'(bad));
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: got timeout expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1;
        mem_read = 0; mem_write = 0; lorD = 0; ir_write = 0;
        pc = '0; alu_out = '0; wdata = '0;
        bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0; bus_if.bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst bus_req", 64'(bus_if.bus_req), 64'd0);
        check_val("rst bus_we", 64'(bus_if.bus_we), 64'd0);
        check_val("rst bus_addr", 64'(bus_if.bus_addr), 64'd0);
        check_val("rst bus_wdata", 64'(bus_if.bus_wdata), 64'd0);
        check_val("rst ir", 64'(ir), 64'd0);
        check_val("rst mdr", 64'(mdr), 64'd0);
        check_val("rst err", 64'(err), 64'd0);
        check_val("rst misalign", 64'(misalign), 64'd0);
        check_val("rst busy", 64'(busy), 64'd0);

        access(1, 0, 0, 1, 32'h10, 32'h0, 32'h0, 32'h00A0_0093, 0, 0, 3, "if_read");
        access(1, 0, 1, 0, 32'h10, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 0, 5, "lw");
        access(0, 1, 1, 0, 32'h14, 32'h200, 32'h1234_5678, 32'h0, 0, 0, 2, "sw");
        access(1, 0, 0, 1, 32'h14, 32'h200, 32'h0, 32'h0000_0513, 0, 0, 3, "if_after_sw");
        access(1, 1, 1, 0, 32'h18, 32'h300, 32'hA5A5_5A5A, 32'h0, 1, 0, 3, "rw_both");
        access(1, 0, 1, 0, 32'h18, 32'h400, 32'h0, 32'h0, -1, 0, TMO + 1, "timeout");
        access(1, 0, 0, 1, 32'h1C, 32'h0, 32'h0, 32'h0000_0297, 0, 2, 5, "after_tmo");

`ifdef MEM_ALIGN_CHECK_EN
        access(1, 0, 1, 0, 32'h20, 32'h102, 32'h0, 32'h0BAD_0BAD, 0, 0, 1, "misalign");
`else
        access(1, 0, 1, 0, 32'h20, 32'h102, 32'h0, 32'h0BAD_0BAD, 0, 0, 3, "misalign");
`endif
        @(negedge clk);
        #1;
        check_val("misalign pulse end", 64'(misalign), 64'd0);

        // Reset lands while the read is in WAIT; the late rvalid must be dropped.
        @(negedge clk);
        mem_read = 1; lorD = 0; ir_write = 1; pc = 32'h24;
        exp_q.push_back('{we: 1'b0, addr: 32'h24, wdata: 32'h0});
        @(negedge clk);
        #1;
        check_val("rstwait bus_req", 64'(bus_if.bus_req), 64'd1);
        if (exp_q.size() != 0) begin
            req_t e;
            e = exp_q.pop_front();
            check_val("rstwait bus_addr", 64'(bus_if.bus_addr), 64'(e.addr));
        end
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        bus_if.bus_gnt = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_read = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        bus_if.bus_rvalid = 1'b0;
        #1;
        check_val("rstwait ir", 64'(ir), 64'd0);
        check_val("rstwait mdr", 64'(mdr), 64'd0);
        check_val("rstwait err", 64'(err), 64'd0);
        check_val("rstwait bus_req", 64'(bus_if.bus_req), 64'd0);
        check_val("rstwait busy", 64'(busy), 64'd0);

        check_val("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
